// File: rtl/fp_unpack_pipe.sv
// fp_unpack_pipe: decodes a pair of half- or single-precision operands into
// single-format sign/exponent/mantissa fields plus class bits and an
// invalid-operation flag, then buffers the decoded pair in a small FIFO.
// The FIFO holds decoded results only, so the head entry is presented directly.
module fp_unpack_pipe #(
    parameter int DEPTH = 2,
    parameter bit FTZ   = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                OP_A,
    input  logic [31:0]                OP_B,
    input  logic                       MODE_FP,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       sign_a,
    output logic                       sign_b,
    output logic [7:0]                 exp_a,
    output logic [7:0]                 exp_b,
    output logic [23:0]                mant_a,
    output logic [23:0]                mant_b,
    output logic [3:0]                 cls_a,
    output logic [3:0]                 cls_b,
    output logic [4:0]                 flags,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
        logic [3:0]  cls;
        logic        snan;
    } op_dec_t;

    typedef struct packed {
        logic        sign_a;
        logic [7:0]  exp_a;
        logic [23:0] mant_a;
        logic [3:0]  cls_a;
        logic        sign_b;
        logic [7:0]  exp_b;
        logic [23:0] mant_b;
        logic [3:0]  cls_b;
        logic [4:0]  flags;
    } entry_t;

    // Classification always uses the source-format fields; denormal flushing
    // only rewrites the value fields and reports the operand as zero+denorm.
    function automatic op_dec_t decode(input logic [31:0] op, input logic single);
        op_dec_t     d;
        logic [7:0]  e8;
        logic [22:0] f23;
        logic [4:0]  e5;
        logic [9:0]  m10;
        logic [4:0]  p;
        logic [22:0] sh;
        d   = '0;
        e8  = op[30:23];
        f23 = op[22:0];
        e5  = op[14:10];
        m10 = op[9:0];
        p   = '0;
        sh  = '0;
        if (single) begin
            d.sign = op[31];
            d.cls  = {(e8 == 8'hFF) && (f23 != '0), (e8 == 8'hFF) && (f23 == '0),
                      (e8 == 8'h00) && (f23 == '0), (e8 == 8'h00) && (f23 != '0)};
            d.snan = d.cls[3] && !f23[22];
            d.exp  = e8;
            d.mant = {(e8 != 8'h00), f23};
        end else begin
            d.sign = op[15];
            d.cls  = {(e5 == 5'h1F) && (m10 != '0), (e5 == 5'h1F) && (m10 == '0),
                      (e5 == 5'h00) && (m10 == '0), (e5 == 5'h00) && (m10 != '0)};
            d.snan = d.cls[3] && !m10[9];
            if (e5 == 5'h1F) begin
                // Half inf/NaN carry no hidden bit
                d.exp  = 8'hFF;
                d.mant = {1'b0, m10, 13'b0};
            end else if (e5 != 5'h00) begin
                d.exp  = {3'b000, e5} + 8'd112;
                d.mant = {1'b1, m10, 13'b0};
            end else if (m10 != '0) begin
                // Half denormals are always representable as single normals
                for (int i = 0; i < 10; i++) begin
                    if (m10[i]) p = 5'(i);
                end
                d.exp  = {3'b000, p} + 8'd103;
                sh     = {13'b0, m10} << (5'd23 - p);
                d.mant = {1'b1, sh};
            end
        end
        if (FTZ && d.cls[0]) begin
            d.exp  = '0;
            d.mant = '0;
            d.cls  = 4'b0011;
        end
        return d;
    endfunction

    op_dec_t dec_a;
    op_dec_t dec_b;
    entry_t  new_entry;
    entry_t  head;
    entry_t  mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign dec_a = decode(OP_A, MODE_FP);
    assign dec_b = decode(OP_B, MODE_FP);

    assign new_entry = '{sign_a: dec_a.sign, exp_a: dec_a.exp, mant_a: dec_a.mant, cls_a: dec_a.cls,
                         sign_b: dec_b.sign, exp_b: dec_b.exp, mant_b: dec_b.mant, cls_b: dec_b.cls,
                         flags: {(dec_a.snan || dec_b.snan), 4'b0000}};

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage for decoded entries; validity is tracked by count alone
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_entry;
    end

    // Head entry is forced to zero when empty so reset leaves outputs clean
    assign head   = out_valid ? mem[rd_ptr] : '0;
    assign sign_a = head.sign_a;
    assign exp_a  = head.exp_a;
    assign mant_a = head.mant_a;
    assign cls_a  = head.cls_a;
    assign sign_b = head.sign_b;
    assign exp_b  = head.exp_b;
    assign mant_b = head.mant_b;
    assign cls_b  = head.cls_b;
    assign flags  = head.flags;

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Scoreboard bench for fp_unpack_pipe: two instances (FTZ=0 and FTZ=1) share
// stimulus; the driver queues hand-computed expectations on each accepted
// pair and a negedge monitor compares every popped head entry.
module tb_fp_unpack_pipe;

    typedef struct packed {
        logic        sa;
        logic [7:0]  ea;
        logic [23:0] ma;
        logic [3:0]  ca;
        logic        sb;
        logic [7:0]  eb;
        logic [23:0] mb;
        logic [3:0]  cb;
        logic [4:0]  fl;
    } ent_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        mode;
        ent_t        e;
        logic        fa;
        logic        fb;
    } vec_t;

    logic        clk, rst, in_valid, out_ready, mode_fp;
    logic [31:0] op_a, op_b;

    logic        in_ready0, out_valid0, sa0, sb0;
    logic [7:0]  ea0, eb0;
    logic [23:0] ma0, mb0;
    logic [3:0]  ca0, cb0;
    logic [4:0]  fl0;
    logic [1:0]  cnt0;

    logic        in_ready1, out_valid1, sa1, sb1;
    logic [7:0]  ea1, eb1;
    logic [23:0] ma1, mb1;
    logic [3:0]  ca1, cb1;
    logic [4:0]  fl1;
    logic [1:0]  cnt1;

    ent_t got0, got1;
    assign got0 = {sa0, ea0, ma0, ca0, sb0, eb0, mb0, cb0, fl0};
    assign got1 = {sa1, ea1, ma1, ca1, sb1, eb1, mb1, cb1, fl1};

    fp_unpack_pipe #(.DEPTH(2), .FTZ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .OP_A(op_a), .OP_B(op_b), .MODE_FP(mode_fp),
        .out_valid(out_valid0), .out_ready(out_ready),
        .sign_a(sa0), .sign_b(sb0), .exp_a(ea0), .exp_b(eb0),
        .mant_a(ma0), .mant_b(mb0), .cls_a(ca0), .cls_b(cb0),
        .flags(fl0), .count(cnt0)
    );

    fp_unpack_pipe #(.DEPTH(2), .FTZ(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .OP_A(op_a), .OP_B(op_b), .MODE_FP(mode_fp),
        .out_valid(out_valid1), .out_ready(out_ready),
        .sign_a(sa1), .sign_b(sb1), .exp_a(ea1), .exp_b(eb1),
        .mant_a(ma1), .mant_b(mb1), .cls_a(ca1), .cls_b(cb1),
        .flags(fl1), .count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   pops0    = 0;
    ent_t q0[$];
    ent_t q1[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic mode,
                           input logic sa, input logic [7:0] ea, input logic [23:0] ma, input logic [3:0] ca,
                           input logic sb, input logic [7:0] eb, input logic [23:0] mb, input logic [3:0] cb,
                           input logic [4:0] fl, input logic fa, input logic fb);
        vec_t v;
        v.a = a; v.b = b; v.mode = mode;
        v.e = {sa, ea, ma, ca, sb, eb, mb, cb, fl};
        v.fa = fa; v.fb = fb;
        vecs.push_back(v);
    endtask

    // Flushing an operand that is denormal in its source format
    function automatic ent_t ftz_of(input ent_t e, input logic fa, input logic fb);
        ent_t r;
        r = e;
        if (fa) begin r.ea = '0; r.ma = '0; r.ca = 4'b0011; end
        if (fb) begin r.eb = '0; r.mb = '0; r.cb = 4'b0011; end
        return r;
    endfunction

    task automatic drive(input int idx);
        int   n;
        logic done;
        vec_t v;
        v = vecs[idx];
        op_a = v.a; op_b = v.b; mode_fp = v.mode; in_valid = 1'b1;
        done = 1'b0; n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            if (in_ready0) begin
                q0.push_back(v.e);
                q1.push_back(ftz_of(v.e, v.fa, v.fb));
                done = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!done) check("push_timeout", 128'd0, 128'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        check("drain_q0", 128'(q0.size()), 128'd0);
        check("drain_q1", 128'(q1.size()), 128'd0);
    endtask

    // Monitor: compares each head entry the consumer takes against the queue
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) check("unexpected_out0", 128'(got0), 128'd0);
                else begin
                    check("entry_ftz0", 128'(got0), 128'(q0.pop_front()));
                    pops0++;
                end
            end
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) check("unexpected_out1", 128'(got1), 128'd0);
                else check("entry_ftz1", 128'(got1), 128'(q1.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //      A             B             mode  sa ea     ma          ca       sb eb     mb          cb       fl        fa fb
        add_vec(32'h3F800000, 32'h80000000, 1'b1, 0, 8'h7F, 24'h800000, 4'b0000, 1, 8'h00, 24'h000000, 4'b0010, 5'b00000, 0, 0);
        add_vec(32'hFFFF3C00, 32'h00007C00, 1'b0, 0, 8'h7F, 24'h800000, 4'b0000, 0, 8'hFF, 24'h000000, 4'b0100, 5'b00000, 0, 0);
        add_vec(32'h00000001, 32'h00008000, 1'b0, 0, 8'h67, 24'h800000, 4'b0001, 1, 8'h00, 24'h000000, 4'b0010, 5'b00000, 1, 0);
        add_vec(32'h7F800001, 32'h3F800000, 1'b1, 0, 8'hFF, 24'h800001, 4'b1000, 0, 8'h7F, 24'h800000, 4'b0000, 5'b10000, 0, 0);
        add_vec(32'h7FC00000, 32'h00000000, 1'b1, 0, 8'hFF, 24'hC00000, 4'b1000, 0, 8'h00, 24'h000000, 4'b0010, 5'b00000, 0, 0);
        add_vec(32'h00007D00, 32'h00007E00, 1'b0, 0, 8'hFF, 24'h200000, 4'b1000, 0, 8'hFF, 24'h400000, 4'b1000, 5'b10000, 0, 0);
        add_vec(32'h00000200, 32'h000083FF, 1'b0, 0, 8'h70, 24'h800000, 4'b0001, 1, 8'h70, 24'hFFC000, 4'b0001, 5'b00000, 1, 1);
        add_vec(32'h00000001, 32'h7F800000, 1'b1, 0, 8'h00, 24'h000001, 4'b0001, 0, 8'hFF, 24'h800000, 4'b0100, 5'b00000, 1, 0);
        add_vec(32'h0000C000, 32'h00000400, 1'b0, 1, 8'h80, 24'h800000, 4'b0000, 0, 8'h71, 24'h800000, 4'b0000, 5'b00000, 0, 0);
        add_vec(32'h40490FDB, 32'hFF800001, 1'b1, 0, 8'h80, 24'hC90FDB, 4'b0000, 1, 8'hFF, 24'h800001, 4'b1000, 5'b10000, 0, 0);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode_fp = 1'b0;
        op_a = 32'h3F800000; op_b = 32'h3F800000;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_count0", 128'(cnt0), 128'd0);
        check("rst_count1", 128'(cnt1), 128'd0);
        check("rst_out_valid", 128'(out_valid0), 128'd0);
        check("rst_in_ready", 128'(in_ready0), 128'd1);
        check("rst_data0", 128'(got0), 128'd0);
        check("rst_data1", 128'(got1), 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Streaming with the consumer always ready
        out_ready = 1'b1;
        drive(0);
        @(negedge clk);
        check("latency_out_valid", 128'(out_valid0), 128'd1);
        @(posedge clk); #1;
        for (int i = 1; i < 10; i++) drive(i);
        wait_drain();

        // Backpressure: fill, hold a third pair, then release
        out_ready = 1'b0;
        drive(8);
        drive(9);
        @(negedge clk);
        check("full_count", 128'(cnt0), 128'd2);
        check("full_in_ready", 128'(in_ready0), 128'd0);
        @(posedge clk); #1;
        fork
            drive(3);
            begin
                repeat (3) @(negedge clk);
                check("held_count", 128'(cnt0), 128'd2);
                @(posedge clk); #1;
                out_ready = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("drain_out_valid", 128'(out_valid0), 128'd1);
                end
            end
        join
        wait_drain();

        // Asynchronous reset mid-stream discards both entries
        out_ready = 1'b0;
        drive(1);
        drive(2);
        @(negedge clk);
        check("pre_rst_count", 128'(cnt0), 128'd2);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst_count", 128'(cnt0), 128'd0);
        check("async_rst_out_valid", 128'(out_valid0), 128'd0);
        check("async_rst_in_ready", 128'(in_ready0), 128'd1);
        check("async_rst_count1", 128'(cnt1), 128'd0);
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(5);
        @(negedge clk);
        check("post_rst_latency", 128'(out_valid0), 128'd1);
        @(posedge clk); #1;
        wait_drain();
        check("total_pops", 128'(pops0), 128'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_unpack_pipe.md
FP_UNPACK_PIPE -- requirements
Module: fp_unpack_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of decoded-result FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter FTZ, default 0, meaning 1 = flush denormal inputs to signed zero.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair present.
REQ-006 SHALL have port in_ready  output  1  block can accept a pair.
REQ-007 SHALL have ports OP_A, OP_B  input  32 each  raw operands (half mode: bits [15:0] only).
REQ-008 SHALL have port MODE_FP  input  1  0 = half, 1 = single, sampled with each accepted pair.
REQ-009 SHALL have port out_valid  output  1  head entry valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes head entry.
REQ-011 SHALL have ports sign_a, sign_b  output  1 each  operand sign.
REQ-012 SHALL have ports exp_a, exp_b  output  8 each  exponent re-biased to single (bias 127).
REQ-013 SHALL have ports mant_a, mant_b  output  24 each  {hidden bit, 23-bit fraction}.
REQ-014 SHALL have ports cls_a, cls_b  output  4 each  {nan, inf, zero, denorm} of the source operand.
REQ-015 SHALL have port flags  output  5  {NV, DZ, OF, UF, NX}.
REQ-016 SHALL have port count  output  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL equal (count < DEPTH), independent of out_ready; out_valid SHALL equal (count != 0).
REQ-019 Decode SHALL be computed before the push; the FIFO SHALL store decoded results only; outputs SHALL show the head entry.
REQ-020 Latency: a pair pushed at edge k into an empty FIFO SHALL be visible with out_valid=1 after edge k.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order. Pointers SHALL wrap modulo DEPTH.
REQ-022 Single mode: exponent passes through. Fraction = OP[22:0]. Hidden bit = (exp != 0).
REQ-023 Half normal (exp 1..30): exp = e+112. Fraction = {m10, 13'b0}. Hidden bit 1.
REQ-024 Half exp 31: exp = 255. Fraction = {m10, 13'b0}.
REQ-025 Half denormal (m10 != 0, leading-one position p in 0..9): exp = p+103. Fraction = (m10 << (23-p))[22:0]. Hidden bit 1.
REQ-026 Zero inputs (either mode) SHALL give exp 0, mant 0, sign preserved.
REQ-027 FTZ=1: any denormal SHALL give exp 0, mant 0, sign preserved, cls zero=1 and denorm=1.
REQ-028 nan = (exp all-ones && frac != 0); inf = (exp all-ones && frac == 0); zero = (exp 0 && frac 0); denorm = (exp 0 && frac != 0). All use source-format fields.
REQ-029 sNaN SHALL mean nan with fraction MSB = 0 (bit 22 single, bit 9 half).
REQ-030 flags.NV SHALL be 1 iff A or B is sNaN. DZ, OF, UF, NX SHALL be 0. flags SHALL be stored per entry.
REQ-031 A push while full SHALL be impossible (in_ready=0); a pop while empty SHALL be ignored.

Reset
REQ-032 While rst=1, count, pointers, out_valid and all data outputs SHALL be 0, and in_ready SHALL be 1.
REQ-033 Reset asserted mid-stream SHALL immediately discard all entries; no stale entry SHALL appear after release.

Verification
REQ-034 Single mode, A=0x3F800000, B=0x80000000 -> next cycle: exp_a=0x7F, mant_a=0x800000, cls_a=0000; sign_b=1, cls_b=0010, flags=0.
REQ-035 Half mode, A=0x3C00, B=0x7C00 -> exp_a=0x7F, mant_a=0x800000; exp_b=0xFF, mant_b=0x000000, cls_b=0100.
REQ-036 Half mode, A=0x0001, FTZ=0 -> exp_a=0x67, mant_a=0x800000, cls_a=0001; FTZ=1 -> exp_a=0, mant_a=0, cls_a=0011.
REQ-037 Single mode, A=0x7F800001 -> cls_a=1000, flags=5'b10000; A=0x7FC00000 -> flags=0.
REQ-038 DEPTH=2, out_ready=0, push 3 pairs -> count=2 and in_ready=0 after the 2nd push; 3rd pair held; out_ready=1 -> pairs emerge in order, one per cycle.
REQ-039 With count=2, pulse rst -> count=0, out_valid=0, in_ready=1 asynchronously; the next push appears after 1 cycle.
